// File: rtl/psr_cond_unit.sv
// psr_cond_unit
//   Holds the architectural PSR {N,Z,L,F,C} (bit0=C, 1=F, 2=L, 3=Z, 4=N).
//   It evaluates 4-bit branch/jump condition codes against the PSR and
//   returns a registered taken/not-taken answer over a valid/ready
//   handshake. A small save/restore stack keeps the PSR across interrupt
//   entry and exit.
// Ports
//   clk, reset_n            rising-edge clock, async active-low reset
//   alu_flags, flag_we      ALU flag vector and per-bit PSR write enables
//   cond_valid/ready/code   condition request handshake
//   taken_valid/ready/taken registered result handshake
//   psr_push, psr_pop       save/restore the PSR to/from the stack
//   psr                     architectural PSR
//   stk_full/empty/err      stack status; stk_err is sticky until reset
module psr_cond_unit #(
   parameter int DEPTH = 4,
   parameter int PTRW  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] alu_flags,
   input  logic [4:0] flag_we,
   input  logic       cond_valid,
   input  logic [3:0] cond_code,
   output logic       cond_ready,
   output logic       taken_valid,
   output logic       taken,
   input  logic       taken_ready,
   input  logic       psr_push,
   input  logic       psr_pop,
   output logic [4:0] psr,
   output logic       stk_full,
   output logic       stk_empty,
   output logic       stk_err
);

   logic [4:0]    stack [DEPTH];
   logic [PTRW:0] count;
   logic [PTRW:0] count_m1;
   logic [PTRW-1:0] top_idx;
   logic [4:0]    top;
   logic [4:0]    merged;
   logic [4:0]    eff;
   logic          pop_acc, swap, push_wr, push_inc, err_set, accept;

   assign stk_full  = (count == (PTRW+1)'(DEPTH));
   assign stk_empty = (count == '0);
   assign count_m1  = count - (PTRW+1)'(1);
   assign top_idx   = count_m1[PTRW-1:0];
   assign top       = stack[top_idx];

   // A pop is honoured whenever the stack holds something; with a push in
   // the same cycle it becomes a swap of PSR and top, count unchanged.
   assign pop_acc  = psr_pop & ~stk_empty;
   assign swap     = psr_push & pop_acc;
   assign push_wr  = psr_push & (swap | ~stk_full);
   assign push_inc = psr_push & ~psr_pop & ~stk_full
                   | psr_push & psr_pop & stk_empty;
   assign err_set  = (psr_push & ~psr_pop & stk_full)
                   | (psr_pop & ~psr_push & stk_empty);

   // Effective PSR: same-cycle flag writes bypass, but a restore overrides.
   // This is also exactly the next PSR value.
   assign merged = (alu_flags & flag_we) | (psr & ~flag_we);
   assign eff    = pop_acc ? top : merged;

   assign cond_ready = ~taken_valid | taken_ready;
   assign accept     = cond_valid & cond_ready;

   function automatic logic eval(input logic [3:0] cc, input logic [4:0] f);
      logic c, fl, l, z, n;
      {n, z, l, fl, c} = f;
      case (cc)
         4'h0: eval = z;
         4'h1: eval = ~z;
         4'h2: eval = c;
         4'h3: eval = ~c;
         4'h4: eval = l;
         4'h5: eval = ~l;
         4'h6: eval = n;
         4'h7: eval = ~n;
         4'h8: eval = fl;
         4'h9: eval = ~fl;
         4'hA: eval = ~l & ~z;
         4'hB: eval = l | z;
         4'hC: eval = ~n & ~z;
         4'hD: eval = n | z;
         4'hE: eval = 1'b1;
         default: eval = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psr         <= '0;
         taken_valid <= 1'b0;
         taken       <= 1'b0;
         count       <= '0;
         stk_err     <= 1'b0;
      end else begin
         psr <= eff;
         if (accept) begin
            taken_valid <= 1'b1;
            taken       <= eval(cond_code, eff);
         end else if (taken_ready) begin
            taken_valid <= 1'b0;
         end
         if (push_inc)
            count <= count + (PTRW+1)'(1);
         else if (pop_acc && !swap)
            count <= count_m1;
         if (err_set)
            stk_err <= 1'b1;
      end
   end

   // Stack contents need no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push_wr)
         stack[swap ? top_idx : count[PTRW-1:0]] <= psr;
   end

endmodule

// File: tb/tb_psr_cond_unit.sv
module tb_psr_cond_unit;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] alu_flags, flag_we;
   logic       cond_valid, cond_ready, taken_valid, taken, taken_ready;
   logic [3:0] cond_code;
   logic       psr_push, psr_pop, stk_full, stk_empty, stk_err;
   logic [4:0] psr;

   int checks = 0;
   int errors = 0;

   psr_cond_unit #(.DEPTH(4), .PTRW(2)) dut (
      .clk(clk), .reset_n(reset_n), .alu_flags(alu_flags), .flag_we(flag_we),
      .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready),
      .taken_valid(taken_valid), .taken(taken), .taken_ready(taken_ready),
      .psr_push(psr_push), .psr_pop(psr_pop), .psr(psr),
      .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] af, we;
      logic       cv;
      logic [3:0] cc;
      logic       tr, push, pop;
      logic       rdy, tv, tk;
      logic [4:0] psr;
      logic       full, empty, err;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic [4:0] af, input logic [4:0] we, input logic cv,
                      input logic [3:0] cc, input logic tr, input logic push,
                      input logic pop, input logic rdy, input logic tv,
                      input logic tk, input logic [4:0] p, input logic full,
                      input logic empty, input logic err);
      vec_t v;
      v.af = af; v.we = we; v.cv = cv; v.cc = cc; v.tr = tr; v.push = push;
      v.pop = pop; v.rdy = rdy; v.tv = tv; v.tk = tk; v.psr = p;
      v.full = full; v.empty = empty; v.err = err;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; alu_flags = '0; flag_we = '0; cond_valid = 0;
      cond_code = '0; taken_ready = 1; psr_push = 0; psr_pop = 0;

      //   af       we     cv cc   tr pu po | rdy tv tk psr     fu em er
      // flag bypass into the same-cycle evaluation
      add(5'h08, 5'h1F, 1, 4'h0, 1, 0, 0,  1, 1, 1, 5'h08, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h1, 1, 0, 0,  1, 1, 0, 5'h08, 0, 1, 0);
      // psr = L only; taken holds with no new request
      add(5'h04, 5'h1F, 0, 4'h0, 1, 0, 0,  1, 0, 0, 5'h04, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'hB, 1, 0, 0,  1, 1, 1, 5'h04, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'hA, 1, 0, 0,  1, 1, 0, 5'h04, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'hE, 1, 0, 0,  1, 1, 1, 5'h04, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'hF, 1, 0, 0,  1, 1, 0, 5'h04, 0, 1, 0);
      // partial flag write: only C
      add(5'h1F, 5'h01, 1, 4'h2, 1, 0, 0,  1, 1, 1, 5'h05, 0, 1, 0);
      // back-pressure: CS result held for 3 cycles, then back-to-back
      add(5'h00, 5'h00, 1, 4'h2, 1, 0, 0,  1, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h3, 0, 0, 0,  0, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h3, 0, 0, 0,  0, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h3, 0, 0, 0,  0, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h3, 1, 0, 0,  1, 1, 0, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h2, 1, 0, 0,  1, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 0, 4'h0, 1, 0, 0,  1, 0, 1, 5'h05, 0, 1, 0);
      // remaining codes against psr = L|C
      add(5'h00, 5'h00, 1, 4'h4, 1, 0, 0,  1, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h5, 1, 0, 0,  1, 1, 0, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h6, 1, 0, 0,  1, 1, 0, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h7, 1, 0, 0,  1, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h8, 1, 0, 0,  1, 1, 0, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'h9, 1, 0, 0,  1, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'hC, 1, 0, 0,  1, 1, 1, 5'h05, 0, 1, 0);
      add(5'h00, 5'h00, 1, 4'hD, 1, 0, 0,  1, 1, 0, 5'h05, 0, 1, 0);
      // swap: count=1, top=0A, psr=11; CS sees popped value, flag_we ignored
      add(5'h0A, 5'h1F, 0, 4'h0, 1, 0, 0,  1, 0, 0, 5'h0A, 0, 1, 0);
      add(5'h11, 5'h1F, 0, 4'h0, 1, 1, 0,  1, 0, 0, 5'h11, 0, 0, 0);
      add(5'h1F, 5'h1F, 1, 4'h2, 1, 1, 1,  1, 1, 0, 5'h0A, 0, 0, 0);
      // pop beats flag_we, evaluation uses the popped value
      add(5'h00, 5'h1F, 1, 4'h2, 1, 0, 1,  1, 1, 1, 5'h11, 0, 1, 0);
      // push & pop on empty: push only, no error
      add(5'h00, 5'h00, 0, 4'h0, 1, 1, 1,  1, 0, 1, 5'h11, 0, 0, 0);
      add(5'h00, 5'h00, 0, 4'h0, 1, 0, 1,  1, 0, 1, 5'h11, 0, 1, 0);
      // fill to DEPTH with 1,2,3,4 then overflow
      add(5'h01, 5'h1F, 0, 4'h0, 1, 0, 0,  1, 0, 1, 5'h01, 0, 1, 0);
      add(5'h02, 5'h1F, 0, 4'h0, 1, 1, 0,  1, 0, 1, 5'h02, 0, 0, 0);
      add(5'h03, 5'h1F, 0, 4'h0, 1, 1, 0,  1, 0, 1, 5'h03, 0, 0, 0);
      add(5'h04, 5'h1F, 0, 4'h0, 1, 1, 0,  1, 0, 1, 5'h04, 0, 0, 0);
      add(5'h00, 5'h1F, 0, 4'h0, 1, 1, 0,  1, 0, 1, 5'h00, 1, 0, 0);
      add(5'h00, 5'h00, 0, 4'h0, 1, 1, 0,  1, 0, 1, 5'h00, 1, 0, 1);
      // drain in LIFO order, then underflow
      add(5'h00, 5'h00, 0, 4'h0, 1, 0, 1,  1, 0, 1, 5'h04, 0, 0, 1);
      add(5'h00, 5'h00, 0, 4'h0, 1, 0, 1,  1, 0, 1, 5'h03, 0, 0, 1);
      add(5'h00, 5'h00, 0, 4'h0, 1, 0, 1,  1, 0, 1, 5'h02, 0, 0, 1);
      add(5'h00, 5'h00, 0, 4'h0, 1, 0, 1,  1, 0, 1, 5'h01, 0, 1, 1);
      add(5'h00, 5'h00, 0, 4'h0, 1, 0, 1,  1, 0, 1, 5'h01, 0, 1, 1);
      // leave a result pending for the reset check
      add(5'h00, 5'h00, 1, 4'hE, 0, 0, 0,  1, 1, 1, 5'h01, 0, 1, 1);

      // reset state while reset is held
      #12;
      chk("rst_psr", psr, 5'h00);
      chk("rst_tv", {4'b0, taken_valid}, 5'h0);
      chk("rst_empty", {4'b0, stk_empty}, 5'h1);
      chk("rst_err", {4'b0, stk_err}, 5'h0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      foreach (vt[i]) begin
         alu_flags = vt[i].af; flag_we = vt[i].we; cond_valid = vt[i].cv;
         cond_code = vt[i].cc; taken_ready = vt[i].tr;
         psr_push = vt[i].push; psr_pop = vt[i].pop;
         #1;
         chk($sformatf("v%0d_rdy", i), {4'b0, cond_ready}, {4'b0, vt[i].rdy});
         @(posedge clk); #1;
         chk($sformatf("v%0d_tv", i), {4'b0, taken_valid}, {4'b0, vt[i].tv});
         chk($sformatf("v%0d_tk", i), {4'b0, taken}, {4'b0, vt[i].tk});
         chk($sformatf("v%0d_psr", i), psr, vt[i].psr);
         chk($sformatf("v%0d_stk", i), {2'b0, stk_full, stk_empty, stk_err},
             {2'b0, vt[i].full, vt[i].empty, vt[i].err});
      end

      // async reset mid-transaction: taken_valid=1, psr=1, stk_err=1
      cond_valid = 0; taken_ready = 0; psr_push = 0; psr_pop = 0; flag_we = 0;
      #2;
      chk("pre_tv", {4'b0, taken_valid}, 5'h1);
      reset_n = 1'b0;
      #1;
      chk("arst_psr", psr, 5'h00);
      chk("arst_tv", {4'b0, taken_valid}, 5'h0);
      chk("arst_tk", {4'b0, taken}, 5'h0);
      chk("arst_stk", {2'b0, stk_full, stk_empty, stk_err}, 5'b00010);
      chk("arst_rdy", {4'b0, cond_ready}, 5'h1);
      #3;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_tv", {4'b0, taken_valid}, 5'h0);
      chk("post_psr", psr, 5'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
